// File: rtl/tlb_maint_ctrl_if.sv
// Command, TLB-port and completion signals between the WB-stage maintenance
// logic / TLB array (master) and the tlb_maint_ctrl sequencer (slave).
interface tlb_maint_ctrl_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  // Command handshake
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [IDXW-1:0] cmd_index;
  logic [88:0]     cmd_entry;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vppn;

  // TLB write/read ports
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic [88:0]     tlb_w_entry;
  logic [IDXW-1:0] tlb_r_index;
  logic [88:0]     tlb_r_entry;

  // Completion
  logic            done;
  logic            done_err;
  logic [88:0]     rd_entry;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_entry, inv_op, inv_asid, inv_vppn,
    output tlb_r_entry,
    input  cmd_ready, tlb_we, tlb_w_index, tlb_w_entry, tlb_r_index,
    input  done, done_err, rd_entry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_entry, inv_op, inv_asid, inv_vppn,
    input  tlb_r_entry,
    output cmd_ready, tlb_we, tlb_w_index, tlb_w_entry, tlb_r_index,
    output done, done_err, rd_entry
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: owns the TLB read/write ports for TLBRD, TLBWR,
// TLBFILL and INVTLB. INVTLB walks every entry, one per cycle, clearing E on hits.
// Optional macro TLB_MAINT_LFSR_EN: FILL index from an LFSR instead of a counter.
module tlb_maint_ctrl #(
  parameter int TLBNUM = 16
) (
  input logic             clk,
  input logic             reset,
  tlb_maint_ctrl_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SWEEP, S_RESP} state_t;
  typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_FILL = 2'd2, OP_INV = 2'd3} op_t;

  state_t          r_state, w_next;
  op_t             r_op;
  logic [IDXW-1:0] r_index;
  logic [88:0]     r_entry;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vppn;
  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] r_fill;
  logic            r_err;
  logic [88:0]     r_rd_entry;

  logic            w_accept;
  logic            w_inv_ok;
  logic            w_ready;
  logic            w_we;
  logic [IDXW-1:0] w_widx;
  logic [88:0]     w_wentry;
  logic [IDXW-1:0] w_ridx;
  logic            w_done;
  logic            w_hit;
  logic            w_vamatch;
  logic            w_asid_eq;

  logic [18:0]     w_e_vppn;
  logic [5:0]      w_e_ps;
  logic [9:0]      w_e_asid;
  logic            w_e_g;

  // Acceptance is decoded from the state directly so it never loops through cmd_ready.
  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  assign w_inv_ok = (bus.inv_op <= 5'd6);

  assign w_e_vppn = bus.tlb_r_entry[87:69];
  assign w_e_ps   = bus.tlb_r_entry[68:63];
  assign w_e_asid = bus.tlb_r_entry[62:53];
  assign w_e_g    = bus.tlb_r_entry[52];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Command latch, sweep counter, error flag and TLBRD result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= OP_RD;
      r_index    <= '0;
      r_entry    <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_rd_entry <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= op_t'(bus.cmd_op);
        r_index    <= bus.cmd_index;
        r_entry    <= bus.cmd_entry;
        r_inv_op   <= bus.inv_op;
        r_inv_asid <= bus.inv_asid;
        r_inv_vppn <= bus.inv_vppn;
        r_cnt      <= '0;
        r_err      <= (bus.cmd_op == OP_INV) && !w_inv_ok;
      end else if (r_state == S_SWEEP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_EXEC && r_op == OP_RD) r_rd_entry <= bus.tlb_r_entry;
    end
  end

`ifdef TLB_MAINT_LFSR_EN
  logic w_fb;

  // Feedback taps per table size; every sequence is maximal and skips zero.
  if (TLBNUM == 8) begin : g_tap8
    assign w_fb = r_fill[2] ^ r_fill[1];
  end else if (TLBNUM == 16) begin : g_tap16
    assign w_fb = r_fill[3] ^ r_fill[2];
  end else begin : g_tap32
    assign w_fb = r_fill[4] ^ r_fill[2];
  end

  // Fill index LFSR, advancing every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (reset) r_fill <= IDXW'(1);
    else       r_fill <= {r_fill[IDXW-2:0], w_fb};
  end
`else
  // Fill index counter, advancing every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (reset) r_fill <= '0;
    else       r_fill <= r_fill + 1'b1;
  end
`endif

  // INVTLB hit condition for the entry currently on the read port.
  always_comb begin
    w_asid_eq = (w_e_asid == r_inv_asid);
    w_vamatch = (w_e_vppn[18:10] == r_inv_vppn[18:10]) &&
                ((w_e_ps == 6'd22) || (w_e_vppn[9:0] == r_inv_vppn[9:0]));
    w_hit = 1'b0;
    case (r_inv_op)
      5'd0, 5'd1: w_hit = 1'b1;
      5'd2:       w_hit = w_e_g;
      5'd3:       w_hit = !w_e_g;
      5'd4:       w_hit = !w_e_g && w_asid_eq;
      5'd5:       w_hit = !w_e_g && w_asid_eq && w_vamatch;
      5'd6:       w_hit = (w_e_g || w_asid_eq) && w_vamatch;
      default:    w_hit = 1'b0;
    endcase
  end

  // Read port index; kept apart from the write logic, which depends on the read data.
  always_comb begin
    w_ridx = '0;
    if (!reset) begin
      if (r_state == S_EXEC && r_op == OP_RD) w_ridx = r_index;
      else if (r_state == S_SWEEP)            w_ridx = r_cnt;
    end
  end

  // Next state and write/handshake/done outputs; reset forces idle outputs immediately.
  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_we     = 1'b0;
    w_widx   = '0;
    w_wentry = '0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (bus.cmd_op != OP_INV) w_next = S_EXEC;
          else if (w_inv_ok)        w_next = S_SWEEP;
          else                      w_next = S_RESP;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
        case (r_op)
          OP_WR: begin
            w_we     = 1'b1;
            w_widx   = r_index;
            w_wentry = r_entry;
          end
          OP_FILL: begin
            w_we     = 1'b1;
            w_widx   = r_fill;
            w_wentry = r_entry;
          end
          default: ;
        endcase
      end
      S_SWEEP: begin
        w_widx   = r_cnt;
        w_we     = bus.tlb_r_entry[88] && w_hit;
        w_wentry = {1'b0, bus.tlb_r_entry[87:0]};
        if (r_cnt == LAST_IDX) w_next = S_RESP;
      end
      S_RESP: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Synchronous reset still gates outputs in the cycle it is sampled, so an
    // interrupted sweep stops writing in that very cycle.
    if (reset) begin
      w_ready  = 1'b1;
      w_we     = 1'b0;
      w_widx   = '0;
      w_wentry = '0;
      w_done   = 1'b0;
    end
  end

  assign bus.cmd_ready   = w_ready;
  assign bus.tlb_we      = w_we;
  assign bus.tlb_w_index = w_widx;
  assign bus.tlb_w_entry = w_wentry;
  assign bus.tlb_r_index = w_ridx;
  assign bus.done        = w_done;
  assign bus.done_err    = w_done && r_err;
  assign bus.rd_entry    = r_rd_entry;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: stimulus pushes expected TLB writes and
// done pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_tlb_maint_ctrl;
  localparam int TLBNUM = 16;
  localparam int IDXW   = $clog2(TLBNUM);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tlb_maint_ctrl_if #(.TLBNUM(TLBNUM)) bus ();
  tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (.clk(clk), .reset(reset), .bus(bus));

  // TLB array seen by the DUT
  logic [88:0] mem [TLBNUM];
  assign bus.tlb_r_entry = mem[bus.tlb_r_index];
  always @(posedge clk) if (bus.tlb_we) mem[bus.tlb_w_index] <= bus.tlb_w_entry;

  // Reference state
  logic [88:0]     ref_mem [TLBNUM];
  logic [88:0]     model_rd;
  int unsigned     cyc = 0;
  logic [IDXW-1:0] model_fill;

  typedef struct {
    bit              is_done;
    int unsigned     cyc;
    logic [IDXW-1:0] idx;
    logic [88:0]     entry;
    bit              err;
    logic [88:0]     rd;
  } ev_t;
  ev_t expq[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

`ifdef TLB_MAINT_LFSR_EN
  localparam logic [IDXW-1:0] FILL_SEED = IDXW'(1);
`else
  localparam logic [IDXW-1:0] FILL_SEED = '0;
`endif

  function automatic logic [IDXW-1:0] next_fill(input logic [IDXW-1:0] v);
`ifdef TLB_MAINT_LFSR_EN
    int unsigned tapmask;
    logic [IDXW-1:0] m;
    tapmask = (TLBNUM == 8) ? 32'h6 : (TLBNUM == 16) ? 32'hC : 32'h14;
    m = tapmask[IDXW-1:0];
    return {v[IDXW-2:0], ^(v & m)};
`else
    return IDXW'((int'(v) + 1) % TLBNUM);
`endif
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    model_fill <= reset ? FILL_SEED : next_fill(model_fill);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the next expected event whenever the DUT writes or finishes.
  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      check("cmd_ready", 96'(bus.cmd_ready), 96'(expq.size() == 0));
      if (bus.tlb_we) begin
        if (expq.size() == 0 || expq[0].is_done) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got index %0d entry %h expected no write (cycle %0d)",
                   bus.tlb_w_index, bus.tlb_w_entry, cyc);
        end else begin
          ev = expq.pop_front();
          check("wr_cycle", 96'(cyc), 96'(ev.cyc));
          check("wr_index", 96'(bus.tlb_w_index), 96'(ev.idx));
          check("wr_entry", 96'(bus.tlb_w_entry), 96'(ev.entry));
        end
      end
      if (bus.done) begin
        if (expq.size() == 0 || !expq[0].is_done) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected pending write or nothing (cycle %0d)", cyc);
        end else begin
          ev = expq.pop_front();
          check("done_cycle", 96'(cyc), 96'(ev.cyc));
          check("done_err", 96'(bus.done_err), 96'(ev.err));
          check("rd_entry", 96'(bus.rd_entry), 96'(ev.rd));
        end
      end
    end
  end

  function automatic bit inv_hit(input logic [4:0] op, input logic [88:0] e,
                                 input logic [9:0] asid, input logic [18:0] vppn);
    logic [18:0] ev;
    bit g, asid_eq, va;
    ev      = e[87:69];
    g       = e[52];
    asid_eq = (e[62:53] == asid);
    va      = (ev[18:10] == vppn[18:10]) && ((e[68:63] == 6'd22) || (ev[9:0] == vppn[9:0]));
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && asid_eq;
      5'd5:       return !g && asid_eq && va;
      5'd6:       return (g || asid_eq) && va;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [88:0] mk_entry(input bit e, input logic [18:0] vppn, input logic [5:0] ps,
                                           input logic [9:0] asid, input bit g,
                                           input logic [19:0] ppn0, input bit v0);
    return {e, vppn, ps, asid, g, ppn0, 2'b00, 2'b00, 1'b0, v0, 20'h0, 2'b00, 2'b00, 1'b0, 1'b0};
  endfunction

  function automatic logic [88:0] rand_entry();
    logic [95:0] r;
    logic [88:0] e;
    r = {$urandom, $urandom, $urandom};
    e = r[88:0];
    e[88]    = ($urandom_range(0, 7) != 0);
    e[87:69] = {9'(9'h100 + $urandom_range(0, 1)), 10'($urandom_range(0, 3))};
    e[68:63] = ($urandom_range(0, 1) != 0) ? 6'd22 : 6'd12;
    e[62:53] = 10'($urandom_range(1, 3));
    return e;
  endfunction

  // Issue one command. cut < TLBNUM interrupts an INV sweep with reset at sweep cycle cut.
  task automatic issue(input logic [1:0] op, input logic [IDXW-1:0] idx, input logic [88:0] ent,
                       input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vppn,
                       input int cut);
    int unsigned c;
    ev_t ev;
    logic [88:0] e;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_index = idx;
    bus.cmd_entry = ent;
    bus.inv_op    = iop;
    bus.inv_asid  = asid;
    bus.inv_vppn  = vppn;
    @(posedge clk);
    #1;
    c = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_index = IDXW'($urandom);
    bus.cmd_entry = {$urandom, $urandom, $urandom};
    bus.inv_op    = 5'($urandom);
    bus.inv_asid  = 10'($urandom);
    bus.inv_vppn  = 19'($urandom);
    ev = '{is_done: 1'b0, cyc: c, idx: '0, entry: '0, err: 1'b0, rd: '0};
    case (op)
      2'd0: begin
        model_rd = ref_mem[idx];
      end
      2'd1, 2'd2: begin
        ev.idx   = (op == 2'd1) ? idx : model_fill;
        ev.entry = ent;
        ref_mem[ev.idx] = ent;
        expq.push_back(ev);
      end
      default: begin
        if (iop > 5'd6) begin
          ev = '{is_done: 1'b1, cyc: c, idx: '0, entry: '0, err: 1'b1, rd: model_rd};
          expq.push_back(ev);
        end else begin
          for (int k = 0; k < TLBNUM && k < cut; k++) begin
            e = ref_mem[k];
            if (e[88] && inv_hit(iop, e, asid, vppn)) begin
              e[88] = 1'b0;
              ref_mem[k] = e;
              ev = '{is_done: 1'b0, cyc: c + k, idx: IDXW'(k), entry: e, err: 1'b0, rd: '0};
              expq.push_back(ev);
            end
          end
          if (cut >= TLBNUM) begin
            ev = '{is_done: 1'b1, cyc: c + TLBNUM, idx: '0, entry: '0, err: 1'b0, rd: model_rd};
            expq.push_back(ev);
          end
        end
      end
    endcase
    if (op != 2'd3) begin
      ev = '{is_done: 1'b1, cyc: c + 1, idx: '0, entry: '0, err: 1'b0, rd: model_rd};
      expq.push_back(ev);
    end
    if (op == 2'd3 && iop <= 5'd6 && cut < TLBNUM) begin
      repeat (cut) @(posedge clk);
      #1;
      reset = 1'b1;
      expq.delete();
      model_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
    end else begin
      for (int n = 0; n < TLBNUM + 8 && expq.size() != 0; n++) @(posedge clk);
      if (expq.size() != 0) begin
        checks++; failures++;
        $display("FAIL timeout: got %0d events outstanding expected 0 (cycle %0d)", expq.size(), cyc);
        expq.delete();
      end
    end
  endtask

  task automatic wr(input int i, input logic [88:0] e);
    issue(2'd1, IDXW'(i), e, 5'd0, 10'd0, 19'd0, TLBNUM);
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    issue(2'd3, '0, '0, op, asid, vppn, TLBNUM);
  endtask

  task automatic rd(input int i);
    issue(2'd0, IDXW'(i), '0, 5'd0, 10'd0, 19'd0, TLBNUM);
  endtask

  initial begin
    int r;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_index = '0;
    bus.cmd_entry = '0;
    bus.inv_op    = '0;
    bus.inv_asid  = '0;
    bus.inv_vppn  = '0;
    model_rd      = '0;
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 96'(bus.tlb_we), 96'(0));
    check("rst_done", 96'(bus.done), 96'(0));
    check("rst_ready", 96'(bus.cmd_ready), 96'(1));
    check("rst_rd_entry", 96'(bus.rd_entry), 96'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_r_index", 96'(bus.tlb_r_index), 96'(0));
    check("idle_w_index", 96'(bus.tlb_w_index), 96'(0));
    check("idle_w_entry", 96'(bus.tlb_w_entry), 96'(0));
    check("idle_done_err", 96'(bus.done_err), 96'(0));
    mon_en = 1'b1;

    // Single write then read back
    wr(5, mk_entry(1'b1, 19'h12345, 6'd12, 10'h3, 1'b0, 20'hABCDE, 1'b1));
    rd(5);

    // Populate every entry, then invalidate all
    for (int i = 0; i < TLBNUM; i++) wr(i, rand_entry() | {1'b1, 88'h0});
    inv(5'd0, 10'd0, 19'd0);
    rd($urandom_range(0, TLBNUM - 1));

    // ASID-selective invalidate leaves globals and other ASIDs alone
    wr(2, mk_entry(1'b1, 19'h00100, 6'd12, 10'd3, 1'b1, 20'h2, 1'b1));
    wr(3, mk_entry(1'b1, 19'h00100, 6'd12, 10'd3, 1'b0, 20'h3, 1'b1));
    wr(4, mk_entry(1'b1, 19'h00100, 6'd12, 10'd4, 1'b0, 20'h4, 1'b1));
    inv(5'd4, 10'd3, 19'd0);
    rd(2); rd(3); rd(4);

    // 4MB page: low 10 VPPN bits ignored
    wr(6, mk_entry(1'b1, 19'h40000, 6'd22, 10'd1, 1'b0, 20'h6, 1'b1));
    inv(5'd5, 10'd1, 19'h403FF);
    wr(6, mk_entry(1'b1, 19'h40000, 6'd22, 10'd1, 1'b0, 20'h6, 1'b1));
    inv(5'd5, 10'd1, 19'h40400);
    rd(6);

    // Unsupported op
    inv(5'd9, 10'd1, 19'h0);

    // Reset during sweep cycle 5
    for (int i = 0; i < TLBNUM; i++) wr(i, rand_entry() | {1'b1, 88'h0});
    issue(2'd3, '0, '0, 5'd0, 10'd0, 19'd0, 5);
    rd(4); rd(5);

    // Fill sequence
    for (int i = 0; i < TLBNUM - 1; i++) issue(2'd2, '0, rand_entry(), 5'd0, 10'd0, 19'd0, TLBNUM);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) rd($urandom_range(0, TLBNUM - 1));
      else if (r < 5) wr($urandom_range(0, TLBNUM - 1), rand_entry());
      else if (r < 7) issue(2'd2, IDXW'($urandom), rand_entry(), 5'd0, 10'd0, 19'd0, TLBNUM);
      else inv(5'($urandom_range(0, 8)), 10'($urandom_range(1, 3)),
               {9'(9'h100 + $urandom_range(0, 1)), 10'($urandom_range(0, 3))});
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < TLBNUM; i++) check("tlb_contents", 96'(mem[i]), 96'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
